kuz_scheduler: RTL

Shares a single Kuznyechik (GOST R 34.12-2015) encryption core between `N_REQ` requesters. Round-robin arbitration, a cached-key check that skips re-expansion when the next key matches the loaded one, level-based sequencing of the core's `read_key`/`read_word` lines, per-requester response handshakes, and a watchdog that aborts a hung core. Sits between the requester ports and the `main` core instance.

---
 rtl/kuz_pkg.sv | 25 ++
 rtl/kuz_rr_arbiter.sv | 37 +++
 rtl/kuz_scheduler.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/kuz_pkg.sv
// kuz_pkg: shared types and constants for the Kuznyechik core scheduler.
//   KEY_W / BLK_W : key and block widths of the cipher core.
//   kuz_state_e   : scheduler sequencing states.
//   wrap_idx      : modular index helper used by the round-robin arbiter.
package kuz_pkg;

    localparam int unsigned KEY_W = 256;
    localparam int unsigned BLK_W = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DROP,
        ST_KEY,
        ST_RUN,
        ST_RESP,
        ST_ABORT
    } kuz_state_e;

    function automatic int unsigned wrap_idx(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/kuz_rr_arbiter.sv
// kuz_rr_arbiter: round-robin grant over N_REQ requesters.
//   req_valid [N_REQ-1:0] : pending requests.
//   rr_ptr    [PTR_W-1:0] : highest-priority index for this decision.
//   grant     [N_REQ-1:0] : one-hot grant, first valid index at or after rr_ptr.
//   grant_idx [PTR_W-1:0] : binary index of the granted requester.
//   grant_any             : some requester is granted.
module kuz_rr_arbiter
    import kuz_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_any
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            cand = PTR_W'(wrap_idx(32'(rr_ptr), off, N_REQ));
            if (!grant_any && req_valid[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/kuz_scheduler.sv
// kuz_scheduler: shares one Kuznyechik encryption core between N_REQ requesters.
//   clk, rst_n            : clock (rising edge), async active-low reset.
//   req_valid/req_ready   : per-requester request handshake (ready = grant in IDLE).
//   req_key, req_word     : packed per-requester key (256b) and block (128b), index 0 in LSBs.
//   rsp_valid/rsp_ready   : per-requester response handshake, only the owner's ready counts.
//   rsp_word, rsp_err     : shared ciphertext bus and timeout flag, held through RESP.
//   core_read_key/_input_key   : key-load level and key to the core.
//   core_read_word/_input_word : block-start level and block to the core.
//   core_output_word, core_write, core_ready : core result, result pulse, expansion done.
module kuz_scheduler
    import kuz_pkg::*;
#(
    parameter int unsigned N_REQ       = 2,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*KEY_W-1:0] req_key,
    input  logic [N_REQ*BLK_W-1:0] req_word,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [BLK_W-1:0]       rsp_word,
    output logic                   rsp_err,
    output logic                   core_read_key,
    output logic [KEY_W-1:0]       core_input_key,
    output logic                   core_read_word,
    output logic [BLK_W-1:0]       core_input_word,
    input  logic [BLK_W-1:0]       core_output_word,
    input  logic                   core_write,
    input  logic                   core_ready
);

    localparam int unsigned PTR_W = $clog2(N_REQ);
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

    kuz_state_e state, state_nxt;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] grant_idx;
    logic [N_REQ-1:0] grant;
    logic             grant_any;
    logic             accept;

    logic [KEY_W-1:0] key_reg;
    logic [KEY_W-1:0] cached_key;
    logic [BLK_W-1:0] word_reg;
    logic             key_valid;
    logic [KEY_W-1:0] sel_key;
    logic [BLK_W-1:0] sel_word;
    logic             key_hit;

    logic [WD_W-1:0]  wd_cnt;
    logic             wd_expired;

    kuz_rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Key/word of the granted requester.
    always_comb begin
        sel_key  = '0;
        sel_word = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_key  = req_key[i*KEY_W +: KEY_W];
                sel_word = req_word[i*BLK_W +: BLK_W];
            end
        end
    end

    assign key_hit    = (sel_key == cached_key);
    assign accept     = (state == ST_IDLE) && grant_any;
    assign wd_expired = (wd_cnt == WD_LAST);

    // key_reg only changes on accept, and a changed key always passes through
    // DROP with read_key low, so the key bus is stable whenever read_key is high.
    assign core_input_key  = key_reg;
    assign core_input_word = word_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        req_ready      = '0;
        rsp_valid      = '0;
        core_read_key  = 1'b0;
        core_read_word = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready     = grant;
                // A loaded key stays presented between blocks so a hit skips expansion.
                core_read_key = key_valid;
                if (grant_any) begin
                    if (key_valid && key_hit) begin
                        state_nxt = ST_RUN;
                    end else if (key_valid) begin
                        state_nxt = ST_DROP;
                    end else begin
                        state_nxt = ST_KEY;
                    end
                end
            end
            ST_DROP: begin
                state_nxt = ST_KEY;
            end
            ST_KEY: begin
                core_read_key = 1'b1;
                // Completion in the expiry cycle takes priority over abort.
                if (core_ready) begin
                    state_nxt = ST_RUN;
                end else if (wd_expired) begin
                    state_nxt = ST_ABORT;
                end
            end
            ST_RUN: begin
                core_read_key  = 1'b1;
                core_read_word = 1'b1;
                if (core_write) begin
                    state_nxt = ST_RESP;
                end else if (wd_expired) begin
                    state_nxt = ST_ABORT;
                end
            end
            ST_RESP: begin
                rsp_valid[owner] = 1'b1;
                core_read_key    = key_valid;
                if (rsp_ready[owner]) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ABORT: begin
                state_nxt = ST_RESP;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            owner      <= '0;
            key_reg    <= '0;
            word_reg   <= '0;
            cached_key <= '0;
            key_valid  <= 1'b0;
            wd_cnt     <= '0;
            rsp_word   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            // Watchdog restarts on every state change and only runs in KEY/RUN.
            if (state_nxt != state) begin
                wd_cnt <= '0;
            end else if (state == ST_KEY || state == ST_RUN) begin
                wd_cnt <= wd_cnt + 1'b1;
            end

            if (accept) begin
                key_reg  <= sel_key;
                word_reg <= sel_word;
                owner    <= grant_idx;
                rr_ptr   <= (grant_idx == PTR_LAST) ? '0 : grant_idx + 1'b1;
            end

            case (state)
                ST_DROP: begin
                    key_valid <= 1'b0;
                end
                ST_KEY: begin
                    if (core_ready) begin
                        cached_key <= key_reg;
                        key_valid  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (core_write) begin
                        rsp_word <= core_output_word;
                        rsp_err  <= 1'b0;
                    end
                end
                ST_ABORT: begin
                    key_valid <= 1'b0;
                    rsp_word  <= '0;
                    rsp_err   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
